// File: rtl/bus_slave_if_pkg.sv
// -----------------------------------------------------------------------------
// bus_slave_if_pkg
// Shared definitions for the bus slave responder. It provides the bus word
// widths, the READ/WRITE encodings, the active-low enable encodings and the
// responder state encoding.
// -----------------------------------------------------------------------------
package bus_slave_if_pkg;

  localparam int WORD_DATA_W = 32;
  localparam int WORD_ADDR_W = 30;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  // Active-low strobes such as rdy_ are asserted with ENABLE_.
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam int BUS_SLAVE_STATE_W = 2;

  typedef enum logic [BUS_SLAVE_STATE_W-1:0] {
    BUS_SLAVE_STATE_IDLE  = 2'd0,
    BUS_SLAVE_STATE_REQ   = 2'd1,
    BUS_SLAVE_STATE_WAIT  = 2'd2,
    BUS_SLAVE_STATE_READY = 2'd3
  } bus_slave_state_e;

endpackage

// File: rtl/bus_slave_if.sv
// -----------------------------------------------------------------------------
// bus_slave_if
// This is the slave-side responder for the on-chip bus. When cs_ and as_ are
// both low, it latches the request and drives it onto a local device port.
// After the device acks, it waits an optional number of wait states and then
// returns a one-cycle active-low rdy_ together with the read data. If the
// device never answers, the cycle is completed with an error.
//
// Ports
//   clk, reset     system clock and synchronous active-high reset
//   cs_, as_       slave select and address strobe (active low)
//   rw, addr       access direction (READ/WRITE) and word address
//   wr_data        write data from the master
//   rd_data        read data; nonzero only while rdy_ is low
//   rdy_           one-cycle active-low completion strobe
//   dev_req        level request to the device; it holds until ack or timeout
//   dev_rw/addr/wr_data   latched request fields for the device
//   dev_rd_data    device read data, sampled in the ack cycle
//   dev_ack        device done; it is only looked at while a request is pending
//   timeout_err    one-cycle pulse that accompanies an error completion
// -----------------------------------------------------------------------------
module bus_slave_if
  import bus_slave_if_pkg::*;
#(
  parameter int DEV_ADDR_W  = 8,
  parameter int WAIT_CYCLES = 0,
  parameter int TIMEOUT     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cs_,
  input  logic                   as_,
  input  logic                   rw,
  input  logic [WORD_ADDR_W-1:0] addr,
  input  logic [WORD_DATA_W-1:0] wr_data,
  output logic [WORD_DATA_W-1:0] rd_data,
  output logic                   rdy_,
  output logic                   dev_req,
  output logic                   dev_rw,
  output logic [DEV_ADDR_W-1:0]  dev_addr,
  output logic [WORD_DATA_W-1:0] dev_wr_data,
  input  logic [WORD_DATA_W-1:0] dev_rd_data,
  input  logic                   dev_ack,
  output logic                   timeout_err
);

  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [3:0]       WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  bus_slave_state_e state, state_nx;

  logic [WORD_DATA_W-1:0] rd_buf;
  logic [TMO_W-1:0]       tmo_cnt;
  logic [3:0]             wait_cnt;
  logic                   err_flag;

  logic accept;
  logic ack_done;
  logic tmo_done;

  // The decoder handles the address bits above the device window.
  generate
    if (DEV_ADDR_W < WORD_ADDR_W) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^addr[WORD_ADDR_W-1:DEV_ADDR_W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) state <= BUS_SLAVE_STATE_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    ack_done = 1'b0;
    tmo_done = 1'b0;
    case (state)
      BUS_SLAVE_STATE_IDLE: begin
        // A strobe that is still low in the rdy_ cycle belongs to the access
        // that just finished. It is not the start of a new access.
        if (!cs_ && !as_ && (rdy_ == DISABLE_)) begin
          accept   = 1'b1;
          state_nx = BUS_SLAVE_STATE_REQ;
        end
      end
      BUS_SLAVE_STATE_REQ: begin
        // If the ack arrives in the final timeout cycle, the ack wins.
        if (dev_ack) begin
          ack_done = 1'b1;
          state_nx = (WAIT_CYCLES == 0) ? BUS_SLAVE_STATE_READY : BUS_SLAVE_STATE_WAIT;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_done = 1'b1;
          state_nx = BUS_SLAVE_STATE_READY;
        end
      end
      BUS_SLAVE_STATE_WAIT: begin
        if (wait_cnt == 4'd0) state_nx = BUS_SLAVE_STATE_READY;
      end
      BUS_SLAVE_STATE_READY: state_nx = BUS_SLAVE_STATE_IDLE;
      default:               state_nx = BUS_SLAVE_STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdy_        <= DISABLE_;
      rd_data     <= '0;
      timeout_err <= 1'b0;
      dev_req     <= 1'b0;
      dev_rw      <= READ;
      dev_addr    <= '0;
      dev_wr_data <= '0;
      rd_buf      <= '0;
      tmo_cnt     <= '0;
      wait_cnt    <= '0;
      err_flag    <= 1'b0;
    end else begin
      // By default the completion strobes are deasserted and rd_data is zero.
      rdy_        <= DISABLE_;
      rd_data     <= '0;
      timeout_err <= 1'b0;

      if (accept) begin
        dev_req     <= 1'b1;
        dev_rw      <= rw;
        dev_addr    <= addr[DEV_ADDR_W-1:0];
        dev_wr_data <= wr_data;
        tmo_cnt     <= '0;
      end

      if ((state == BUS_SLAVE_STATE_REQ) && !dev_ack && !tmo_done)
        tmo_cnt <= tmo_cnt + TMO_W'(1);

      if (ack_done) begin
        dev_req  <= 1'b0;
        rd_buf   <= (dev_rw == READ) ? dev_rd_data : '0;
        wait_cnt <= WAIT_INIT;
      end

      if (tmo_done) begin
        dev_req  <= 1'b0;
        rd_buf   <= '0;
        err_flag <= 1'b1;
      end

      if ((state == BUS_SLAVE_STATE_WAIT) && (wait_cnt != 4'd0))
        wait_cnt <= wait_cnt - 4'd1;

      if (state == BUS_SLAVE_STATE_READY) begin
        rdy_        <= ENABLE_;
        rd_data     <= rd_buf;
        timeout_err <= err_flag;
        err_flag    <= 1'b0;
        dev_rw      <= READ;
        dev_addr    <= '0;
        dev_wr_data <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bus_slave_if.sv
// -----------------------------------------------------------------------------
// tb_bus_slave_if
// This bench uses directed vectors. Two responders share the same stimulus:
// one has no wait states and one has three. Expected values are computed by
// hand from the request/ack timing.
// -----------------------------------------------------------------------------
module tb_bus_slave_if;
  import bus_slave_if_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs_ = 1'b1;
  logic        as_ = 1'b1;
  logic        rw = READ;
  logic [29:0] addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] dev_rd_data = '0;
  logic        dev_ack = 1'b0;

  logic [31:0] rd_data_v [2];
  logic [1:0]  rdy_v;
  logic [1:0]  dev_req_v;
  logic [1:0]  dev_rw_v;
  logic [1:0]  terr_v;
  logic [7:0]  dev_addr_v [2];
  logic [31:0] dev_wd_v [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bus_slave_if #(.DEV_ADDR_W(8), .WAIT_CYCLES(0), .TIMEOUT(16)) dut_w0 (
    .clk(clk), .reset(reset), .cs_(cs_), .as_(as_), .rw(rw), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data_v[0]), .rdy_(rdy_v[0]),
    .dev_req(dev_req_v[0]), .dev_rw(dev_rw_v[0]), .dev_addr(dev_addr_v[0]),
    .dev_wr_data(dev_wd_v[0]), .dev_rd_data(dev_rd_data), .dev_ack(dev_ack),
    .timeout_err(terr_v[0])
  );

  bus_slave_if #(.DEV_ADDR_W(8), .WAIT_CYCLES(3), .TIMEOUT(16)) dut_w3 (
    .clk(clk), .reset(reset), .cs_(cs_), .as_(as_), .rw(rw), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data_v[1]), .rdy_(rdy_v[1]),
    .dev_req(dev_req_v[1]), .dev_rw(dev_rw_v[1]), .dev_addr(dev_addr_v[1]),
    .dev_wr_data(dev_wd_v[1]), .dev_rd_data(dev_rd_data), .dev_ack(dev_ack),
    .timeout_err(terr_v[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One access is issued, then the bench watches both responders for a fixed
  // window. ack_k is the edge after acceptance at which dev_ack is sampled
  // high (0 means never). pulse_k is the edge at which a stray cs_/as_ strobe
  // is presented (0 means never).
  task automatic run_txn(input string name, input logic rw_i, input logic [29:0] a,
                         input logic [31:0] wd, input logic [31:0] rdd,
                         input int ack_k, input int pulse_k,
                         input int exp_k0, input int exp_k3,
                         input logic [31:0] exp_rd, input logic exp_terr,
                         input int exp_req);
    int          rdy_k [2];
    int          npulse [2];
    int          nreq [2];
    int          nbad [2];
    int          exp_k [2];
    logic [31:0] got_rd [2];
    logic        got_terr [2];
    logic [7:0]  a_lo;
    string       pfx;
    a_lo     = a[7:0];
    exp_k[0] = exp_k0;
    exp_k[1] = exp_k3;
    for (int i = 0; i < 2; i++) begin
      rdy_k[i] = -1; npulse[i] = 0; nreq[i] = 0; nbad[i] = 0;
      got_rd[i] = '0; got_terr[i] = 1'b0;
    end
    cs_ = 1'b0; as_ = 1'b0; rw = rw_i; addr = a; wr_data = wd;
    dev_rd_data = rdd; dev_ack = 1'b0;
    tick();
    // The fields are scrambled after acceptance. Only the latched copies matter.
    cs_ = 1'b1; as_ = 1'b1; rw = ~rw_i; addr = ~a; wr_data = ~wd;
    for (int i = 0; i < 2; i++) begin
      pfx = $sformatf("%s w%0d", name, (i == 0) ? 0 : 3);
      check({pfx, " dev_req"},     32'(dev_req_v[i]), 32'd1);
      check({pfx, " dev_rw"},      32'(dev_rw_v[i]),  32'(rw_i));
      check({pfx, " dev_addr"},    32'(dev_addr_v[i]), 32'(a_lo));
      check({pfx, " dev_wr_data"}, dev_wd_v[i], wd);
      if (dev_req_v[i]) nreq[i]++;
    end
    for (int k = 1; k <= 45; k++) begin
      dev_ack = (k == ack_k);
      cs_ = (k == pulse_k) ? 1'b0 : 1'b1;
      as_ = (k == pulse_k) ? 1'b0 : 1'b1;
      tick();
      dev_ack = 1'b0; cs_ = 1'b1; as_ = 1'b1;
      for (int i = 0; i < 2; i++) begin
        if (dev_req_v[i]) nreq[i]++;
        if (rdy_v[i] == 1'b0) begin
          npulse[i]++;
          if (rdy_k[i] < 0) begin
            rdy_k[i] = k; got_rd[i] = rd_data_v[i]; got_terr[i] = terr_v[i];
          end
        end else if ((rd_data_v[i] != 32'd0) || terr_v[i]) begin
          nbad[i]++;
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      pfx = $sformatf("%s w%0d", name, (i == 0) ? 0 : 3);
      check({pfx, " rdy_cycle"},    32'(rdy_k[i]),  32'(exp_k[i]));
      check({pfx, " rdy_pulses"},   32'(npulse[i]), 32'd1);
      check({pfx, " rd_data"},      got_rd[i], exp_rd);
      check({pfx, " timeout_err"},  32'(got_terr[i]), 32'(exp_terr));
      check({pfx, " dev_req_len"},  32'(nreq[i]), 32'(exp_req));
      check({pfx, " idle_outputs"}, 32'(nbad[i]), 32'd0);
      check({pfx, " dev_addr_clr"}, 32'(dev_addr_v[i]), 32'd0);
      check({pfx, " dev_wd_clr"},   dev_wd_v[i], 32'd0);
      check({pfx, " dev_rw_clr"},   32'(dev_rw_v[i]), 32'(READ));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nreq_ign;
    int nrdy_ign;
    int np_rst;

    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset w%0d rdy_", i),        32'(rdy_v[i]), 32'd1);
      check($sformatf("reset w%0d rd_data", i),     rd_data_v[i], 32'd0);
      check($sformatf("reset w%0d dev_req", i),     32'(dev_req_v[i]), 32'd0);
      check($sformatf("reset w%0d dev_rw", i),      32'(dev_rw_v[i]), 32'(READ));
      check($sformatf("reset w%0d dev_addr", i),    32'(dev_addr_v[i]), 32'd0);
      check($sformatf("reset w%0d dev_wr_data", i), dev_wd_v[i], 32'd0);
      check($sformatf("reset w%0d timeout_err", i), 32'(terr_v[i]), 32'd0);
    end

    // as_ low with cs_ high selects some other slave.
    nreq_ign = 0; nrdy_ign = 0;
    cs_ = 1'b1; as_ = 1'b0; addr = 30'h10;
    repeat (6) begin
      tick();
      if (dev_req_v != 2'b00) nreq_ign++;
      if (rdy_v != 2'b11) nrdy_ign++;
    end
    as_ = 1'b1;
    tick();
    check("unselected dev_req", 32'(nreq_ign), 32'd0);
    check("unselected rdy_",    32'(nrdy_ign), 32'd0);

    // name rw addr wd rdd ack pulse rdy@w0 rdy@w3 rd terr req_len
    run_txn("read",     READ,  30'h10,       32'h0,         32'hCAFE_0001, 1,  0, 2,  5,  32'hCAFE_0001, 1'b0, 1);
    run_txn("write",    WRITE, 30'h24,       32'h1234_5678, 32'hDEAD_BEEF, 2,  0, 3,  6,  32'h0,         1'b0, 2);
    run_txn("timeout",  READ,  30'h30,       32'h0,         32'h55AA_55AA, 0,  0, 17, 17, 32'h0,         1'b1, 16);
    run_txn("ack_last", READ,  30'h3FFFF10,  32'h0,         32'hA5A5_0F0F, 16, 0, 17, 20, 32'hA5A5_0F0F, 1'b0, 16);
    run_txn("as_pulse", READ,  30'h08,       32'h0,         32'h1111_2222, 4,  2, 5,  8,  32'h1111_2222, 1'b0, 4);

    // Reset arrives while the three-wait-state responder is in WAIT. At the
    // same point, the zero-wait responder is in READY.
    cs_ = 1'b0; as_ = 1'b0; rw = READ; addr = 30'h44; dev_rd_data = 32'h7777_8888;
    tick();
    cs_ = 1'b1; as_ = 1'b1;
    dev_ack = 1'b1;
    tick();
    dev_ack = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_wait w%0d dev_req", i), 32'(dev_req_v[i]), 32'd0);
      check($sformatf("rst_wait w%0d rdy_", i),    32'(rdy_v[i]), 32'd1);
    end
    np_rst = 0;
    repeat (12) begin
      tick();
      if (rdy_v != 2'b11) np_rst++;
    end
    check("rst_wait late rdy_", 32'(np_rst), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
